// File: rtl/writeback_if.sv
// Shared XLEN package and the valid/ready stream interface used by writeback.
// Master drives tvalid/tdata, slave drives tready.
package riscv_pkg;
  localparam int XLEN = 32;
endpackage

interface axis_if #(
  parameter int W = riscv_pkg::XLEN + 6
);
  logic         tvalid;
  logic         tready;
  logic [W-1:0] tdata;

  modport m (output tvalid, output tdata, input tready);
  modport s (input tvalid, input tdata, output tready);
endinterface

// File: rtl/writeback.sv
// Writeback stage: round-robin merge of ALU/CSR/LSU results into the register file.
// Optional macro WB_RETIRE_CNT_EN adds a 64-bit retired-instruction counter.
module writeback
  import riscv_pkg::*;
#(
  parameter int RR_INIT = 0
) (
  input  logic            clk,
  input  logic            rst,
  axis_if.s               alu_axis_if,
  axis_if.s               csr_axis_if,
  axis_if.s               lsu_axis_if,
  input  logic            invalidate,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            retire
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [63:0]     retire_cnt
`endif
);

  localparam int W = XLEN + 6;
  localparam logic [1:0] P_INIT = 2'(RR_INIT);

  logic [2:0]   valid;
  logic [2:0]   gnt;
  logic [2:0]   rdy;
  logic [1:0]   gidx;
  logic [1:0]   p;
  logic         hs;
  logic [W-1:0] beat;
  logic         b_we;
  logic [4:0]   b_rd;
  logic [XLEN-1:0] b_res;

  assign valid = {lsu_axis_if.tvalid,
                  csr_axis_if.tvalid,
                  alu_axis_if.tvalid};

  // First valid source scanning upward from p, wrapping modulo 3.
  always_comb begin
    gnt  = '0;
    gidx = '0;
    for (int k = 2; k >= 0; k--) begin
      int j;
      j = (int'(p) + k) % 3;
      if (valid[j]) begin
        gidx = 2'(j);
      end
    end
    if (|valid) begin
      gnt = 3'b001 << gidx;
    end
  end

  // Flush and reset both close every ready.
  assign rdy = gnt & {3{~invalidate & ~rst}};
  assign alu_axis_if.tready = rdy[0];
  assign csr_axis_if.tready = rdy[1];
  assign lsu_axis_if.tready = rdy[2];
  assign hs = |(valid & rdy);

  // Payload mux for the granted source.
  always_comb begin
    beat = '0;
    unique case (1'b1)
      gnt[0]:  beat = alu_axis_if.tdata;
      gnt[1]:  beat = csr_axis_if.tdata;
      gnt[2]:  beat = lsu_axis_if.tdata;
      default: beat = '0;
    endcase
  end

  assign b_we  = beat[XLEN+5];
  assign b_rd  = beat[XLEN+4:XLEN];
  assign b_res = beat[XLEN-1:0];

  // Advance the round-robin pointer past the granted source on a handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      p <= P_INIT;
    end else if (hs) begin
      p <= (gidx == 2'd2) ? 2'd0 : gidx + 2'd1;
    end
  end

  // Register the accepted beat; x0 writes retire but do not write.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      retire   <= 1'b0;
    end else begin
      retire <= hs;
      rf_we  <= hs & b_we & (b_rd != 5'd0);
      if (hs & b_we & (b_rd != 5'd0)) begin
        rf_waddr <= b_rd;
        rf_wdata <= b_res;
      end
    end
  end

`ifdef WB_RETIRE_CNT_EN
  // Retired-instruction count for minstret, wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      retire_cnt <= '0;
    end else if (retire) begin
      retire_cnt <= retire_cnt + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_writeback.sv
// Self-checking bench for writeback: directed vector table plus
// randomized traffic against a behavioural arbitration model.
module tb_writeback;
  import riscv_pkg::*;

  localparam int W = XLEN + 6;

  logic clk = 1'b0;
  logic rst;
  logic invalidate;
  logic rf_we;
  logic [4:0] rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic retire;
`ifdef WB_RETIRE_CNT_EN
  logic [63:0] retire_cnt;
`endif

  axis_if #(.W(W)) alu_if ();
  axis_if #(.W(W)) csr_if ();
  axis_if #(.W(W)) lsu_if ();

  writeback #(.RR_INIT(0)) dut (
    .clk         (clk),
    .rst         (rst),
    .alu_axis_if (alu_if),
    .csr_axis_if (csr_if),
    .lsu_axis_if (lsu_if),
    .invalidate  (invalidate),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .retire      (retire)
`ifdef WB_RETIRE_CNT_EN
    ,
    .retire_cnt  (retire_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic av, cv, lv;
    logic [W-1:0] ad, cd, ld;
    logic inv, rs;
    logic [2:0] rdy;
    logic we;
    logic [4:0] wa;
    logic [31:0] wd;
    logic ret;
  } vec_t;

  vec_t tv[17];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] bt(input logic we, input logic [4:0] rd,
                                      input logic [31:0] res);
    return {we, rd, res};
  endfunction

  function automatic vec_t mv(
    input logic av, cv, lv,
    input logic [W-1:0] ad, cd, ld,
    input logic inv, rs, input logic [2:0] rdy,
    input logic we, input logic [4:0] wa,
    input logic [31:0] wd, input logic ret);
    vec_t v;
    v.av = av; v.cv = cv; v.lv = lv;
    v.ad = ad; v.cd = cd; v.ld = ld;
    v.inv = inv; v.rs = rs; v.rdy = rdy;
    v.we = we; v.wa = wa; v.wd = wd; v.ret = ret;
    return v;
  endfunction

  function automatic logic [2:0] rdy_now();
    return {lsu_if.tready, csr_if.tready, alu_if.tready};
  endfunction

  task automatic drive(input logic av, cv, lv,
                       input logic [W-1:0] ad, cd, ld,
                       input logic inv, rs);
    alu_if.tvalid = av; alu_if.tdata = ad;
    csr_if.tvalid = cv; csr_if.tdata = cd;
    lsu_if.tvalid = lv; lsu_if.tdata = ld;
    invalidate = inv;
    rst = rs;
  endtask

  task automatic chk_out(input string tag, input logic we,
                         input logic [4:0] wa, input logic [31:0] wd,
                         input logic ret);
    chk({tag, ".rf_we"}, 64'(rf_we), 64'(we));
    chk({tag, ".rf_waddr"}, 64'(rf_waddr), 64'(wa));
    chk({tag, ".rf_wdata"}, 64'(rf_wdata), 64'(wd));
    chk({tag, ".retire"}, 64'(retire), 64'(ret));
  endtask

  // behavioural model state
  int mp;
  logic mwe, mret;
  logic [4:0] mwa;
  logic [31:0] mwd;
  logic [63:0] mcnt;

  initial begin
    logic [W-1:0] a1, c2, l3, x;
    a1 = bt(1, 5'd1, 32'hA1A1_0001);
    c2 = bt(1, 5'd2, 32'hC2C2_0002);
    l3 = bt(1, 5'd3, 32'h3333_0003);
    x  = '0;
    tv[0]  = mv(1,0,0, bt(1,5,32'hDEADBEEF), x, x, 0,0, 3'b001,
                1, 5, 32'hDEADBEEF, 1);
    tv[1]  = mv(0,1,0, x, bt(1,0,32'h1234), x, 0,0, 3'b010,
                0, 5, 32'hDEADBEEF, 1);
    tv[2]  = mv(0,0,0, x, x, x, 0,0, 3'b000, 0, 5, 32'hDEADBEEF, 0);
    tv[3]  = mv(1,0,0, bt(1,7,32'h77), x, x, 0,1, 3'b000, 0, 0, 0, 0);
    tv[4]  = mv(1,1,1, a1, c2, l3, 0,0, 3'b001, 1, 1, 32'hA1A1_0001, 1);
    tv[5]  = mv(1,1,1, a1, c2, l3, 0,0, 3'b010, 1, 2, 32'hC2C2_0002, 1);
    tv[6]  = mv(1,1,1, a1, c2, l3, 0,0, 3'b100, 1, 3, 32'h3333_0003, 1);
    tv[7]  = mv(1,1,1, a1, c2, l3, 0,0, 3'b001, 1, 1, 32'hA1A1_0001, 1);
    tv[8]  = mv(1,1,1, a1, c2, l3, 0,0, 3'b010, 1, 2, 32'hC2C2_0002, 1);
    tv[9]  = mv(1,1,1, a1, c2, l3, 0,0, 3'b100, 1, 3, 32'h3333_0003, 1);
    tv[10] = mv(1,0,0, bt(1,4,32'h44), x, x, 0,0, 3'b001, 1, 4, 32'h44, 1);
    tv[11] = mv(1,0,1, bt(1,4,32'h44), x, bt(1,9,32'h99), 1,0, 3'b000,
                0, 4, 32'h44, 0);
    tv[12] = mv(1,0,1, bt(1,4,32'h44), x, bt(1,9,32'h99), 0,0, 3'b100,
                1, 9, 32'h99, 1);
    tv[13] = mv(1,1,0, bt(1,4,32'h44), bt(0,6,32'h66), x, 0,0, 3'b001,
                1, 4, 32'h44, 1);
    tv[14] = mv(0,0,0, x, x, x, 0,1, 3'b000, 0, 0, 0, 0);
    tv[15] = mv(1,1,0, bt(1,4,32'h44), bt(0,6,32'h66), x, 0,0, 3'b001,
                1, 4, 32'h44, 1);
    tv[16] = mv(0,1,0, x, bt(0,6,32'h66), x, 0,0, 3'b010,
                0, 4, 32'h44, 1);

    // reset with every source offering a beat
    drive(1, 1, 1, a1, c2, l3, 0, 1);
    @(negedge clk);
    @(negedge clk);
    chk("reset.tready", 64'(rdy_now()), 64'(3'b000));
    chk_out("reset", 0, 0, 0, 0);
`ifdef WB_RETIRE_CNT_EN
    chk("reset.retire_cnt", retire_cnt, 64'd0);
`endif

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      if (i > 0) begin
        chk_out($sformatf("vec%0d", i - 1), tv[i-1].we, tv[i-1].wa,
                tv[i-1].wd, tv[i-1].ret);
      end
      drive(tv[i].av, tv[i].cv, tv[i].lv, tv[i].ad, tv[i].cd, tv[i].ld,
            tv[i].inv, tv[i].rs);
      #1;
      chk($sformatf("vec%0d.tready", i), 64'(rdy_now()), 64'(tv[i].rdy));
    end
    @(negedge clk);
    chk_out("vec16", tv[16].we, tv[16].wa, tv[16].wd, tv[16].ret);

    // randomized traffic against the model, starting from reset
    drive(0, 0, 0, x, x, x, 0, 1);
    @(negedge clk);
    rst = 1'b0;
    mp = 0; mwe = 0; mret = 0; mwa = 0; mwd = 0; mcnt = 0;
    for (int n = 0; n < 500; n++) begin
      logic av, cv, lv, inv, rs;
      logic [W-1:0] ad, cd, ld;
      int g;
      logic [2:0] v3, erdy;
      @(negedge clk);
      chk_out($sformatf("rnd%0d", n), mwe, mwa, mwd, mret);
`ifdef WB_RETIRE_CNT_EN
      chk($sformatf("rnd%0d.retire_cnt", n), retire_cnt, mcnt);
`endif
      av = 1'($urandom_range(0, 1));
      cv = 1'($urandom_range(0, 1));
      lv = 1'($urandom_range(0, 1));
      inv = ($urandom_range(0, 7) == 0);
      rs  = ($urandom_range(0, 39) == 0);
      ad = W'({$urandom(), $urandom()});
      cd = W'({$urandom(), $urandom()});
      ld = W'({$urandom(), $urandom()});
      drive(av, cv, lv, ad, cd, ld, inv, rs);
      #1;
      v3 = {lv, cv, av};
      g = -1;
      for (int k = 0; k < 3; k++) begin
        if (g < 0 && v3[(mp + k) % 3]) g = (mp + k) % 3;
      end
      erdy = (g >= 0 && !inv && !rs) ? 3'(1 << g) : 3'b000;
      chk($sformatf("rnd%0d.tready", n), 64'(rdy_now()), 64'(erdy));
      if (rs) begin
        mp = 0; mwe = 0; mret = 0; mwa = 0; mwd = 0; mcnt = 0;
      end else begin
        logic [W-1:0] b;
        mcnt = mcnt + 64'(mret);
        if (erdy != 0) begin
          b = (g == 0) ? ad : (g == 1) ? cd : ld;
          mret = 1;
          mwe = b[XLEN+5] && (b[XLEN+4:XLEN] != 0);
          if (mwe) begin
            mwa = b[XLEN+4:XLEN];
            mwd = b[XLEN-1:0];
          end
          mp = (g + 1) % 3;
        end else begin
          mret = 0;
          mwe = 0;
        end
      end
    end

`ifdef WB_RETIRE_CNT_EN
    // counter wrap from all-ones
    @(negedge clk);
    drive(0, 0, 0, x, x, x, 0, 0);
    @(negedge clk);
    dut.retire_cnt = '1;
    drive(1, 0, 0, bt(1, 8, 32'h8), x, x, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, x, x, x, 0, 0);
    chk("wrap.retire", 64'(retire), 64'd1);
    @(negedge clk);
    chk("wrap.retire_cnt", retire_cnt, 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/writeback.md
WRITEBACK -- requirements
Module: writeback

Interface
REQ-001 SHALL have parameter RR_INIT, default 0, initial round-robin pointer (0=ALU, 1=CSR, 2=LSU).
REQ-002 SHALL use XLEN from riscv_pkg (32); beat payload width W = XLEN+6.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have port alu_axis_if  axis_if.s  W  results from ALU.
REQ-006 SHALL have port csr_axis_if  axis_if.s  W  results from CSR unit (its aluwb output).
REQ-007 SHALL have port lsu_axis_if  axis_if.s  W  results from load/store unit.
REQ-008 SHALL have port invalidate  input  1  pipeline flush; blocks acceptance this cycle.
REQ-009 SHALL have port rf_we  output  1  register-file write enable.
REQ-010 SHALL have port rf_waddr  output  5  destination register index.
REQ-011 SHALL have port rf_wdata  output  XLEN  write data.
REQ-012 SHALL have port retire  output  1  one-cycle pulse per retired beat.
REQ-013 SHALL decode tdata as: bit XLEN+5 = rd_we, bits XLEN+4..XLEN = rd, bits XLEN-1..0 = result.

Function
REQ-014 SHALL accept at most one beat per cycle, on tvalid & tready of the granted source.
REQ-015 SHALL grant round-robin: first valid source scanning from pointer p upward, modulo 3.
REQ-016 SHALL set p to (granted index + 1) mod 3 after a handshake; p unchanged otherwise.
REQ-017 SHALL drive tready = grant & ~invalidate; tready of non-granted sources 0; tready independent of own tvalid only through grant.
REQ-018 SHALL register an accepted beat, so rf_we/rf_waddr/rf_wdata/retire are valid exactly 1 cycle after handshake.
REQ-019 SHALL drive rf_we = rd_we & (rd != 0); writes to x0 suppressed, retire still pulses.
REQ-020 SHALL hold rf_waddr/rf_wdata at last value when rf_we is 0; rf_we and retire 0 in cycles with no prior handshake.
REQ-021 SHALL, when invalidate is high, accept nothing that cycle and leave p unchanged; a beat registered in the previous cycle still writes.
REQ-022 SHALL never backpressure on the output side; register file accepts every write.
REQ-023 SHALL, with all three valid continuously, serve ALU, CSR, LSU, ALU, ... (from p=0) with no bubbles.

Reset
REQ-024 SHALL on rst set rf_we=0, rf_waddr=0, rf_wdata=0, retire=0, p=RR_INIT, all tready=0.
REQ-025 SHALL discard any beat offered in a reset cycle; a registered write pending when rst rises SHALL NOT appear.

Configuration
REQ-026 SHALL, with WB_RETIRE_CNT_EN defined, add output retire_cnt (64 bits, reset 0) incremented by 1 on each retire pulse, wrapping at 2^64-1 to 0, feeding CSR minstret.
REQ-027 SHALL, without WB_RETIRE_CNT_EN, omit retire_cnt port and counter entirely; all other behaviour identical.

Verification
REQ-028 SHALL test: ALU beat rd_we=1, rd=5, result=0xDEADBEEF at cycle T -> rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF, retire=1 at T+1.
REQ-029 SHALL test: CSR beat rd_we=1, rd=0, result=0x1234 -> rf_we=0, retire=1 next cycle.
REQ-030 SHALL test: all three sources valid 6 cycles from reset (RR_INIT=0) -> grant order ALU,CSR,LSU,ALU,CSR,LSU, one write per cycle.
REQ-031 SHALL test: LSU valid, invalidate high one cycle -> lsu tready=0 that cycle, beat accepted next cycle, p unchanged across flush.
REQ-032 SHALL test: rst asserted cycle after handshake -> rf_we=0, retire=0 the following cycle, p=RR_INIT.
REQ-033 SHALL test (WB_RETIRE_CNT_EN): counter preloaded 0xFFFF_FFFF_FFFF_FFFF, one retire -> retire_cnt=0.
